// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one iterative multiplier between two requesters.
// Latency: accept at T, mul_start at T+1, response valid no earlier than T+3; a watchdog
//          aborts a job that has no mul_done after TIMEOUT cycles in WAIT (err=1, data=0).
// Backpressure: one job in flight; requesters are refused until the response handshake completes.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/ready    operand intake handshake, operands req{0,1}_a / req{0,1}_b
//   rsp{0,1}_valid/ready    response handshake, rsp{0,1}_data product, rsp{0,1}_err timeout flag
//   mul_start/x/y           start pulse and held operands towards the multiplier
//   mul_done/result         completion pulse and product from the multiplier
//   busy, grant_id          controller not idle, requester owning the multiplier
module mul_share_ctrl #(
    parameter int A_W     = 32,
    parameter int P_W     = 64,
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [A_W-1:0] req0_a,
    input  logic [A_W-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [A_W-1:0] req1_a,
    input  logic [A_W-1:0] req1_b,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [P_W-1:0] rsp0_data,
    output logic           rsp0_err,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [P_W-1:0] rsp1_data,
    output logic           rsp1_err,

    output logic           mul_start,
    output logic [P_W-1:0] mul_x,
    output logic [A_W-1:0] mul_y,
    input  logic           mul_done,
    input  logic [P_W-1:0] mul_result,

    output logic           busy,
    output logic           grant_id
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             last_srv;
    logic             win;
    logic             accept;
    logic             rsp_hs;
    logic             wd_expired;
    logic [P_W-1:0]   rsp_dat_q;
    logic             rsp_err_q;

    // Round robin: a lone requester always wins; on contention the one not served last wins.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last_srv;
        end else if (req1_valid) begin
            win = 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        mul_start  = 1'b0;
        busy       = (state != IDLE);
        accept     = 1'b0;
        rsp_hs     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !win;
                req1_ready = req1_valid && win;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // mul_done takes priority over a watchdog expiry in the same cycle.
                if (mul_done || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                rsp_hs     = grant_id ? rsp1_ready : rsp0_ready;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_x     <= '0;
            mul_y     <= '0;
            grant_id  <= 1'b0;
            last_srv  <= 1'b1;
            wd_cnt    <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are captured only here, so they stay fixed until the next accept.
                    if (accept) begin
                        mul_x    <= {{(P_W - A_W){1'b0}}, (win ? req1_a : req0_a)};
                        mul_y    <= win ? req1_b : req0_b;
                        grant_id <= win;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (mul_done) begin
                        rsp_dat_q <= mul_result;
                        rsp_err_q <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_srv <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // One response register serves both channels; only the granted channel raises valid.
    assign rsp0_data = rsp_dat_q;
    assign rsp1_data = rsp_dat_q;
    assign rsp0_err  = rsp_err_q;
    assign rsp1_err  = rsp_err_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: drives mul_share_ctrl with directed and random jobs and a behavioural
// multiplier, comparing every response against products, grant order and timing derived
// from the arbitration and watchdog rules.
module tb_mul_share_ctrl;

    localparam int A_W     = 32;
    localparam int P_W     = 64;
    localparam int TIMEOUT = 40;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [A_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic           rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [P_W-1:0] rsp0_data, rsp1_data;
    logic           mul_start, mul_done, busy, grant_id;
    logic [P_W-1:0] mul_x, mul_result;
    logic [A_W-1:0] mul_y;

    int n_chk  = 0;
    int n_pass = 0;
    bit last_srv;

    mul_share_ctrl #(.A_W(A_W), .P_W(P_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        mul_done = 1'b0; mul_result = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        int bad;
        bad = 0;
        if (req0_ready || req1_ready || rsp0_valid || rsp1_valid) bad++;
        if (rsp0_err || rsp1_err || rsp0_data != 0 || rsp1_data != 0) bad++;
        if (mul_start || mul_x != 0 || mul_y != 0 || busy || grant_id) bad++;
        chk(tag, 64'(bad), 64'(0));
    endtask

    // One complete job: accept, start, wait for the multiplier (done on WAIT cycle d, or
    // never when d > TIMEOUT), then hold the response for `hold` cycles before taking it.
    task automatic do_job(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int d, input int hold, input bit stray);
        bit          w, exp_err;
        logic [31:0] wa, wb;
        logic [63:0] prod, exp_dat;
        int          krsp, bad;

        w       = (v0 && v1) ? !last_srv : !v0;
        wa      = w ? a1 : a0;
        wb      = w ? b1 : b0;
        prod    = 64'(wa) * 64'(wb);
        exp_err = (d > TIMEOUT);
        exp_dat = exp_err ? 64'(0) : prod;
        krsp    = (exp_err ? TIMEOUT : d) + 1;

        // accept cycle (a stray mul_done here must be ignored)
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        mul_done = stray; mul_result = {$urandom, $urandom};
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("req0_ready", 64'(req0_ready), 64'(v0 && !w));
        chk("req1_ready", 64'(req1_ready), 64'(v1 && w));
        tick();

        // start cycle: the winner's inputs change and must not matter
        if (w) begin req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; end
        else   begin req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; end
        mul_done = stray; mul_result = {$urandom, $urandom};
        @(negedge clk);
        chk("mul_start", 64'(mul_start), 64'(1));
        chk("mul_x", mul_x, 64'(wa));
        chk("mul_y", 64'(mul_y), 64'(wb));
        chk("grant_id", 64'(grant_id), 64'(w));
        chk("start_rdy", 64'(req0_ready || req1_ready), 64'(0));
        tick();

        bad = 0;
        for (int k = 1; k < krsp; k++) begin
            mul_done   = (k == d);
            mul_result = (k == d) ? prod : {$urandom, $urandom};
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || mul_start || !busy || req0_ready || req1_ready) bad++;
            if (mul_x != 64'(wa) || mul_y != wb) bad++;
            tick();
        end
        chk("wait_quiet", 64'(bad), 64'(0));
        mul_done = 1'b0; mul_result = {$urandom, $urandom};

        bad = 0;
        for (int h = 0; h <= hold; h++) begin
            if (w) begin rsp1_ready = (h == hold); rsp0_ready = 1'($urandom); end
            else   begin rsp0_ready = (h == hold); rsp1_ready = 1'($urandom); end
            @(negedge clk);
            if (h == 0) begin
                chk("rsp_valid", 64'(w ? rsp1_valid : rsp0_valid), 64'(1));
                chk("rsp_other", 64'(w ? rsp0_valid : rsp1_valid), 64'(0));
                chk("rsp_data", w ? rsp1_data : rsp0_data, exp_dat);
                chk("rsp_err", 64'(w ? rsp1_err : rsp0_err), 64'(exp_err));
            end
            if ((w ? rsp1_valid : rsp0_valid) != 1'b1 || (w ? rsp0_valid : rsp1_valid)) bad++;
            if ((w ? rsp1_data : rsp0_data) != exp_dat || (w ? rsp1_err : rsp0_err) != exp_err) bad++;
            if (req0_ready || req1_ready || !busy) bad++;
            tick();
        end
        chk("rsp_hold", 64'(bad), 64'(0));

        idle_inputs();
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_valid", 64'(rsp0_valid || rsp1_valid), 64'(0));
        last_srv = w;
        tick();
    endtask

    initial begin
        int sel, bad;

        idle_inputs();
        reset = 1'b1;
        last_srv = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_state");
        tick();

        // single job, multiplier answers 33 cycles after start
        do_job(1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, 33, 0, 1'b0);

        // contention: grants must alternate
        for (int j = 0; j < 8; j++)
            do_job(1'b1, 1'b1, 32'd2, 32'd3, 32'd4, 32'd5,
                   $urandom_range(1, 10), $urandom_range(0, 2), 1'($urandom));

        // backpressure with the other requester waiting
        do_job(1'b1, 1'b1, 32'd11, 32'd13, 32'd17, 32'd19, 3, 5, 1'b0);

        // watchdog, and done on the final WAIT cycle
        do_job(1'b1, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, TIMEOUT + 10, 1, 1'b0);
        do_job(1'b0, 1'b1, 32'd0, 32'd0, 32'd12, 32'd12, TIMEOUT, 0, 1'b0);

        // max operands
        do_job(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5, 0, 1'b0);

        // reset in the middle of WAIT
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rst_job_start", 64'(mul_start), 64'(1));
        tick();
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        tick();
        mul_done = 1'b1; mul_result = 64'd12;
        tick();
        mul_done = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) bad++;
            tick();
        end
        chk("stray_done", 64'(bad), 64'(0));
        last_srv = 1'b1;
        do_job(1'b0, 1'b1, 32'd0, 32'd0, 32'd21, 32'd2, 4, 0, 1'b0);

        // random traffic
        for (int j = 0; j < 30; j++) begin
            sel = $urandom_range(1, 3);
            do_job(sel[0], sel[1], $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(1, TIMEOUT + 5), $urandom_range(0, 4), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
